// File: rtl/weighted_random_chooser_if.sv
// Request/result bundle of the weighted random chooser: weights, seed control,
// start handshake and the selected segment with its error flag.
interface weighted_random_chooser_if #(
    parameter int N_ITEMS  = 4,
    parameter int WEIGHT_W = 8,
    parameter int LFSR_W   = 16
);
    localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    logic                          in_enable;
    logic                          in_seed_load;
    logic [LFSR_W-1:0]             in_seed;
    logic                          in_start;
    logic [N_ITEMS*WEIGHT_W-1:0]   in_weights;
    logic                          out_busy;
    logic                          out_valid;
    logic [IDX_W-1:0]              out_segment_number;
    logic                          out_error;

    modport master (
        output in_enable, in_seed_load, in_seed, in_start, in_weights,
        input  out_busy, out_valid, out_segment_number, out_error
    );

    modport slave (
        input  in_enable, in_seed_load, in_seed, in_start, in_weights,
        output out_busy, out_valid, out_segment_number, out_error
    );
endinterface

// File: rtl/weighted_random_chooser.sv
// Picks one of N_ITEMS segments with probability weight/sum(weights) using a
// Galois LFSR, a rejection-sampled draw and a sequential cumulative scan.
module weighted_random_chooser #(
    parameter int              N_ITEMS   = 4,
    parameter int              WEIGHT_W  = 8,
    parameter int              LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter int              MAX_RETRY = 3
) (
    input  logic                        in_clock,
    input  logic                        in_reset,
    weighted_random_chooser_if.slave    bus
);
    localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam int SUM_W = WEIGHT_W + $clog2(N_ITEMS);
    localparam int ATT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUM,
        S_DRAW,
        S_SCAN,
        S_DONE
    } state_e;

    state_e                            state_q;
    logic [LFSR_W-1:0]                 lfsr_q;
    logic [N_ITEMS-1:0][WEIGHT_W-1:0]  weights_q;
    logic [SUM_W-1:0]                  sum_q;
    logic [SUM_W-1:0]                  cum_q;
    logic [SUM_W-1:0]                  mask_q;
    logic [SUM_W-1:0]                  rnd_q;
    logic [IDX_W-1:0]                  idx_q;
    logic [IDX_W-1:0]                  seg_q;
    logic [ATT_W-1:0]                  att_q;
    logic                              busy_q;
    logic                              valid_q;
    logic                              error_q;

    logic [LFSR_W-1:0]                 lfsr_d;
    logic [SUM_W-1:0]                  w_cur;
    logic [SUM_W-1:0]                  sum_d;
    logic [SUM_W-1:0]                  cum_d;
    logic [SUM_W-1:0]                  tot_m1;
    logic [SUM_W-1:0]                  mask_d;
    logic [SUM_W-1:0]                  draw;
    logic [SUM_W-1:0]                  draw_fold;

    always_comb begin
        w_cur  = SUM_W'(weights_q[idx_q]);
        sum_d  = sum_q + w_cur;
        cum_d  = cum_q + w_cur;
        // Smearing (total-1) rightwards yields (next power of two >= total) - 1.
        tot_m1 = sum_d - SUM_W'(1);
        mask_d = '0;
        for (int unsigned b = 0; b < SUM_W; b++) begin
            mask_d[b] = |(tot_m1 >> b);
        end
        lfsr_d    = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        draw      = lfsr_d[SUM_W-1:0] & mask_q;
        draw_fold = draw - sum_q;
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q   <= S_IDLE;
            lfsr_q    <= LFSR_W'(1);
            weights_q <= '0;
            sum_q     <= '0;
            cum_q     <= '0;
            mask_q    <= '0;
            rnd_q     <= '0;
            idx_q     <= '0;
            seg_q     <= '0;
            att_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else if (!bus.in_enable) begin
            // Frozen: a pending DONE pulse is re-issued on the next enabled cycle.
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.in_seed_load) begin
                        lfsr_q <= (bus.in_seed == '0) ? LFSR_W'(1) : bus.in_seed;
                    end else if (bus.in_start) begin
                        weights_q <= bus.in_weights;
                        sum_q     <= '0;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_SUM;
                    end
                end
                S_SUM: begin
                    sum_q <= sum_d;
                    if (idx_q == IDX_W'(N_ITEMS - 1)) begin
                        idx_q   <= '0;
                        cum_q   <= '0;
                        att_q   <= '0;
                        mask_q  <= mask_d;
                        state_q <= (sum_d == '0) ? S_DONE : S_DRAW;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_DRAW: begin
                    lfsr_q <= lfsr_d;
                    if (draw < sum_q) begin
                        rnd_q   <= draw;
                        state_q <= S_SCAN;
                    end else if (att_q == ATT_W'(MAX_RETRY)) begin
                        // mask < 2*total, so the folded draw is always in range.
                        rnd_q   <= draw_fold;
                        state_q <= S_SCAN;
                    end else begin
                        att_q <= att_q + ATT_W'(1);
                    end
                end
                S_SCAN: begin
                    cum_q <= cum_d;
                    if (rnd_q < cum_d) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    valid_q <= 1'b1;
                    seg_q   <= idx_q;
                    error_q <= (sum_q == '0);
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.out_busy           = busy_q;
    assign bus.out_valid          = valid_q;
    assign bus.out_segment_number = seg_q;
    assign bus.out_error          = error_q;
endmodule

// File: doc/weighted_random_chooser.md
Name: weighted_random_chooser

Overview:
- Parametrised successor of the 4-way weighted random chooser.
- Selects one of N_ITEMS segments with probability weight_i / sum(weights), using an internal Galois LFSR.
- Sequential datapath: sum pass, rejection-sampled draw, cumulative scan; start/busy/valid handshake, all-zero-weight error flag.
- Feeds the MCMC proposal stage with a segment index.

Parameters:
N_ITEMS, 4, number of weighted items (>=2)
WEIGHT_W, 8, width of each weight (unsigned)
LFSR_W, 16, LFSR width
LFSR_TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1)
MAX_RETRY, 3, rejected draws before deterministic fallback
Derived: IDX_W = max(1, clog2(N_ITEMS)); SUM_W = WEIGHT_W + clog2(N_ITEMS); requires LFSR_W >= SUM_W.

Ports:
in_clock  in  1  clock, rising edge
in_reset  in  1  synchronous, active-high reset
in_enable  in  1  high: FSM and LFSR advance; low: all state frozen, outputs held
in_seed_load  in  1  load in_seed into LFSR (IDLE only)
in_seed  in  LFSR_W  seed; 0 is loaded as 1
in_start  in  1  request one selection (accepted only in IDLE with in_enable=1)
in_weights  in  N_ITEMS*WEIGHT_W  flattened weights, item i at [i*WEIGHT_W +: WEIGHT_W]
out_busy  out  1  high from cycle after accept until DONE exits
out_valid  out  1  one-cycle pulse: result ready
out_segment_number  out  IDX_W  chosen item, held until next out_valid
out_error  out  1  with out_valid: all weights zero; held with segment

Behaviour:
- Reset: state IDLE, LFSR=1, all outputs 0, internal sum/index/cum cleared. Reset wins over everything, including mid-operation.
- in_enable=0: no state, register or LFSR change; out_valid stays low if it would pulse and is issued on the first enabled cycle instead.
- IDLE: in_seed_load has priority over in_start. In the same cycle both are high, seed loads and start is ignored. in_start latches all weights into a shadow register; later in_weights changes have no effect. Next state SUM.
- SUM: one item per cycle, i=0..N_ITEMS-1; total accumulates at SUM_W bits, no overflow possible. After the last item:
  - total==0 -> DONE with error.
  - Otherwise register mask = (smallest power of two >= total) - 1, then go to DRAW.
- DRAW: each cycle, LFSR steps once (Galois: shift right, XOR LFSR_TAPS if LSB was 1), and r = new_lfsr[SUM_W-1:0] & mask.
  - r < total -> store r, go to SCAN.
  - Otherwise count a rejection. On the (MAX_RETRY+1)th attempt, if rejected, use r - total (always < total because mask < 2*total), then go to SCAN.
- SCAN: one item per cycle, cum += w_i. The first i with r < cum stores index i and goes to DONE. Zero-weight items are never selected.
- DONE: out_valid=1 for one cycle, out_segment_number/out_error update the same cycle; out_busy=0 from next cycle; return to IDLE.
- Latency from accept to out_valid: N_ITEMS + attempts + (index+1) + 1 cycles, where attempts is in 1..MAX_RETRY+1. All-zero case: N_ITEMS+1 cycles.
- in_start while busy is ignored, not queued. LFSR steps only in DRAW, so results are deterministic given seed and weights.
- Back-to-back: start is accepted the cycle after DONE.

Test Plan:
- Seed 1, weights {w0..w3}={2,4,2,0}, 4000 starts -> counts ~1000/2000/1000 (±10%), segment 3 count exactly 0, out_error never set.
- Weights {0,0,7,0}, 50 starts -> every out_valid carries segment 2; each latency is 4+attempts+3+1 cycles.
- All weights 0 -> out_valid and out_error high exactly 5 cycles after accept, segment 0, no LFSR step (the next draw matches a fresh seed-1 run).
- Seed load 0 -> identical result sequence to seed load 1. Two runs with the same seed and weights -> identical segment sequences.
- Reset asserted during SCAN -> next cycle out_busy=0, out_valid=0, segment 0, LFSR=1. in_start during busy -> ignored, exactly one out_valid.
- in_enable low for 10 cycles in DRAW -> busy held, LFSR unchanged, result delayed exactly 10 cycles vs. the uninterrupted run, same segment.
